// File: rtl/dl_fifo_pkg.sv
// Shared types for the dl_fifo primitive: the per-cycle transfer operation
// and a helper that classifies the two handshake fires into one.
package dl_fifo_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_DEQ  = 2'b01,
        OP_ENQ  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic enq_fire, input logic deq_fire);
        return fifo_op_e'({enq_fire, deq_fire});
    endfunction

endpackage

// File: rtl/dl_fifo_ptr.sv
// Wrap-bit pointer register: the MSB toggles on each lap of the storage so that
// equal low bits can be told apart as empty or full.
module dl_fifo_ptr #(
    parameter int PTR_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc_i,
    output logic [PTR_BITS-1:0] ptr_o
);

    logic [PTR_BITS-1:0] ptr_q;
    logic [PTR_BITS-1:0] ptr_d;

    // Natural overflow gives the modulo 2*DEPTH wrap.
    always_comb ptr_d = inc_i ? ptr_q + PTR_BITS'(1) : ptr_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/dl_fifo.sv
// Synchronous valid/ready FIFO with show-ahead output. Flags come only from
// registered pointers, so neither side sees a combinational path to the other.
module dl_fifo
    import dl_fifo_pkg::*;
#(
    parameter int NUM_BITS = 32,
    parameter int DEPTH    = 4,
    parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enq_val,
    output logic                enq_rdy,
    input  logic [NUM_BITS-1:0] enq_data,
    output logic                deq_val,
    input  logic                deq_rdy,
    output logic [NUM_BITS-1:0] deq_data,
    output logic [CNT_BITS-1:0] count
);

    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int PTR_BITS  = ADDR_BITS + 1;

    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [NUM_BITS-1:0] mem_q [DEPTH];
    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;
    logic                full;
    logic                empty;
    logic                enq_fire;
    logic                deq_fire;
    fifo_op_e            op;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                   (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);

    assign enq_rdy  = !full;
    assign deq_val  = !empty;
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;
    assign op       = fifo_op(enq_fire, deq_fire);

    dl_fifo_ptr #(.PTR_BITS(PTR_BITS)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (enq_fire),
        .ptr_o (wr_ptr)
    );

    dl_fifo_ptr #(.PTR_BITS(PTR_BITS)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (deq_fire),
        .ptr_o (rd_ptr)
    );

    // NOTE: storage has no reset; the pointers alone decide which entries are
    // live, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_q[wr_ptr[ADDR_BITS-1:0]] <= enq_data;
        end
    end

    assign deq_data = mem_q[rd_ptr[ADDR_BITS-1:0]];

    // NOTE: count_d is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        unique case (op)
            OP_ENQ:  count_d = count_q + CNT_BITS'(1);
            OP_DEQ:  count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_dl_fifo.sv
// Self-checking bench for dl_fifo: a queue-based reference model, a per-cycle
// compare process, directed scenarios with literal expectations, and random traffic.
module tb_dl_fifo;

    localparam int NUM_BITS = 32;
    localparam int DEPTH    = 4;
    localparam int CNT_BITS = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                enq_val;
    logic                enq_rdy;
    logic [NUM_BITS-1:0] enq_data;
    logic                deq_val;
    logic                deq_rdy;
    logic [NUM_BITS-1:0] deq_data;
    logic [CNT_BITS-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NUM_BITS-1:0] model_q [$];

    dl_fifo #(.NUM_BITS(NUM_BITS), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .enq_val  (enq_val),
        .enq_rdy  (enq_rdy),
        .enq_data (enq_data),
        .deq_val  (deq_val),
        .deq_rdy  (deq_rdy),
        .deq_data (deq_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words, updated from the rules
    // "accept when fewer than DEPTH are held, release when at least one is held".
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
        end else begin
            automatic bit do_enq = enq_val && (model_q.size() < DEPTH);
            automatic bit do_deq = deq_rdy && (model_q.size() > 0);
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) model_q.push_back(enq_data);
        end
    end

    // Compare every cycle, mid-period, against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("enq_rdy", 64'(enq_rdy), 64'(model_q.size() != DEPTH));
            check("deq_val", 64'(deq_val), 64'(model_q.size() != 0));
            check("count",   64'(count),   64'(model_q.size()));
            if (model_q.size() != 0) check("deq_data", 64'(deq_data), 64'(model_q[0]));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  accepted;
        int  cyc;
        bit  rdy_now;

        rst      = 1'b1;
        enq_val  = 1'b0;
        deq_rdy  = 1'b0;
        enq_data = '0;
        step();
        step();
        check("rst_deq_val", 64'(deq_val), 64'd0);
        check("rst_enq_rdy", 64'(enq_rdy), 64'd1);
        check("rst_count",   64'(count),   64'd0);
        rst = 1'b0;
        step();

        // Fill to full with 0xA0..0xA3, then hold 0xA4 which must be refused.
        enq_val = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            enq_data = NUM_BITS'(32'hA0 + i);
            step();
            check("fill_count", 64'(count), 64'(i + 1));
        end
        enq_data = 32'hA4;
        check("full_enq_rdy", 64'(enq_rdy), 64'd0);
        step();
        check("full_hold_count", 64'(count), 64'd4);
        check("full_head", 64'(deq_data), 64'hA0);
        enq_val = 1'b0;

        // Drain in order.
        deq_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_data", 64'(deq_data), 64'(32'hA0 + i));
            step();
        end
        check("drain_deq_val", 64'(deq_val), 64'd0);
        check("drain_count",   64'(count),   64'd0);
        deq_rdy = 1'b0;

        // Preload two words, then ten cycles of simultaneous transfer.
        enq_val = 1'b1;
        enq_data = 32'h01;
        step();
        enq_data = 32'h02;
        step();
        deq_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_data = NUM_BITS'(32'h10 + i);
            check("simul_data", 64'(deq_data), (i < 2) ? 64'(32'h01 + i) : 64'(32'h10 + i - 2));
            step();
            check("simul_count", 64'(count), 64'd2);
        end
        deq_rdy = 1'b0;

        // Top up to full (0x18,0x19 held), then full with consumer ready.
        enq_data = 32'h30;
        step();
        enq_data = 32'h31;
        step();
        enq_data = 32'h32;
        deq_rdy  = 1'b1;
        check("fullrdy_enq_rdy", 64'(enq_rdy), 64'd0);
        check("fullrdy_head", 64'(deq_data), 64'h18);
        step();
        deq_rdy = 1'b0;
        check("fullrdy_count_after", 64'(count), 64'd3);
        check("fullrdy_enq_rdy_after", 64'(enq_rdy), 64'd1);
        step();
        enq_val = 1'b0;
        check("fullrdy_count_final", 64'(count), 64'd4);
        check("fullrdy_next_head", 64'(deq_data), 64'h19);

        // Leave three words stored, then reset mid-cycle.
        deq_rdy = 1'b1;
        step();
        deq_rdy = 1'b0;
        check("pre_rst_count", 64'(count), 64'd3);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_deq_val", 64'(deq_val), 64'd0);
        check("async_rst_enq_rdy", 64'(enq_rdy), 64'd1);
        check("async_rst_count",   64'(count),   64'd0);
        #1;
        rst = 1'b0;
        step();
        enq_val  = 1'b1;
        enq_data = 32'h55;
        step();
        enq_val = 1'b0;
        check("post_rst_head", 64'(deq_data), 64'h55);
        check("post_rst_count", 64'(count), 64'd1);
        deq_rdy = 1'b1;
        step();
        deq_rdy = 1'b0;

        // Wrap-around: three rounds of six enqueues interleaved with dequeues.
        for (int r = 0; r < 3; r++) begin
            accepted = 0;
            cyc      = 0;
            enq_val  = 1'b1;
            enq_data = NUM_BITS'(32'h60 + r * 8);
            while (accepted < 6 && cyc < 50) begin
                deq_rdy = (cyc % 2) == 1;
                rdy_now = enq_rdy;
                step();
                cyc++;
                if (rdy_now) begin
                    accepted++;
                    enq_data = enq_data + 1'b1;
                end
            end
            enq_val = 1'b0;
            check("wrap_enq_accepted", 64'(accepted), 64'd6);
            deq_rdy = 1'b1;
            cyc = 0;
            while (deq_val && cyc < 20) begin
                step();
                cyc++;
            end
            deq_rdy = 1'b0;
            check("wrap_drained", 64'(deq_val), 64'd0);
        end

        // Random traffic: producer holds a word until it is accepted.
        rdy_now = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!enq_val || rdy_now) begin
                enq_val  = (i < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                enq_data = $urandom;
            end
            deq_rdy = (i < 750) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            rdy_now = enq_rdy;
            step();
        end

        enq_val = 1'b0;
        deq_rdy = 1'b0;
        step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dl_fifo.md
Name: dl_fifo

Overview:
- Parameterized synchronous FIFO with valid/ready handshakes on both sides; a general-purpose design-library primitive.
- Buffers NUM_BITS-wide words between a producer stage and a consumer stage, for example fetch-to-decode or a writeback queue.
- Decouples the two stages' stall timing so bubbles and back-pressure do not propagate combinationally.

Parameters:
- NUM_BITS, 32, width of each stored word.
- DEPTH, 4, number of entries. Must be a power of two and >= 2.
- CNT_BITS, $clog2(DEPTH)+1, width of the occupancy count. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- enq_val  input  1  producer presents a valid word.
- enq_rdy  output  1  FIFO can accept a word this cycle.
- enq_data  input  NUM_BITS  word to enqueue.
- deq_val  output  1  head word is valid.
- deq_rdy  input  1  consumer accepts the head word this cycle.
- deq_data  output  NUM_BITS  head word (show-ahead).
- count  output  CNT_BITS  current occupancy, 0..DEPTH.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high. Asserting rst immediately clears wr_ptr, rd_ptr and count to 0.
  - During and after reset: deq_val=0, enq_rdy=1, count=0.
  - Storage array is not reset.
- Handshake:
  - Enqueue fire = enq_val & enq_rdy. Dequeue fire = deq_val & deq_rdy.
  - A transfer occurs only on a rising clk edge where fire is 1.
  - enq_val/enq_data must be held stable by the producer until fire. This is not checked in RTL.
- Flags:
  - enq_rdy = !full; deq_val = !empty. Both are derived from registered pointers only.
  - Neither depends combinationally on enq_val or deq_rdy, so there are no ready/valid combinational loops.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide. The MSB is a wrap bit; the low bits index storage.
  - empty: pointers are equal. full: low bits are equal and MSBs differ.
  - Pointers wrap modulo 2*DEPTH by natural overflow.
- Data path:
  - deq_data = mem[rd_ptr low bits], combinational read.
  - deq_data is don't-care while deq_val=0.
  - On enqueue fire, mem[wr_ptr] <= enq_data and wr_ptr increments.
  - On dequeue fire, rd_ptr increments.
- Latency:
  - A word enqueued at edge N is visible on deq_data with deq_val=1 in the cycle after edge N.
  - There is no same-cycle bypass when empty.
- Simultaneous enqueue and dequeue fire (only possible when neither full nor empty): both pointers advance and count is unchanged.
- Full: enq_rdy=0 even if deq_rdy=1 in the same cycle. No pass-through; the slot frees on the next edge.
- Empty: deq_val=0. A deq_rdy assertion is ignored and has no effect on state.
- count: registered.
  - +1 on enqueue-only fire; -1 on dequeue-only fire; unchanged on both or neither.
  - Must always equal wr_ptr - rd_ptr modulo 2*DEPTH.
- Reset mid-operation: all stored words are discarded. The FIFO reports empty asynchronously, without waiting for a clock edge.

Decomposition:
- No shared package is required. DEPTH and NUM_BITS are local parameters only.
- One natural sub-module: dl_fifo_ptr, a wrap-bit pointer register with increment enable and asynchronous active-high reset to 0.
  - Instantiated twice, for write and read.
- Full/empty/count logic stays in dl_fifo.

Test Plan:
- Reset check: assert rst mid-stream with 3 words stored -> deq_val=0, enq_rdy=1 and count=0 immediately, before the next clk edge. The next dequeue returns only words enqueued after reset.
- Fill to full: DEPTH=4, enq_val=1, deq_rdy=0, enqueue 0xA0..0xA3 -> count steps 1,2,3,4. enq_rdy=0 after the 4th edge. A 5th word 0xA4 held on enq_data is not accepted.
- Drain in order: from full, deq_rdy=1, enq_val=0 -> deq_data reads 0xA0,0xA1,0xA2,0xA3 on successive cycles. deq_val=0 and count=0 after the 4th edge.
- Simultaneous transfer: count=2, enq_val=1 and deq_rdy=1 for 10 cycles with data 0x10..0x19 -> count stays 2. Outputs are the 2 preloaded words, then 0x10..0x17 in order.
- Wrap-around: 3 rounds of enqueue-6/dequeue-6 with DEPTH=4 interleaved, pointers crossing 2*DEPTH -> no lost, duplicated or reordered words. count always matches the scoreboard.
- Full with consumer ready: full, deq_rdy=1, enq_val=1 -> that cycle enq_rdy=0 and the head is dequeued. The next cycle enq_rdy=1 and the word is accepted, leaving count=4.
